// File: rtl/i2c_master_arbiter_pkg.sv
// Shared types and constants for the i2c_master request arbiter.
package i2c_arb_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, GAP, RESP} arb_state_t;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_NACK    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;

  // Counter width able to hold max_val; never below one bit.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction
endpackage

// File: rtl/i2c_master_arbiter_if.sv
// Requester handshake plus i2c_master control bundle seen by the arbiter.
interface i2c_master_arbiter_if #(parameter int NUM_REQ = 3);
  import i2c_arb_pkg::*;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_rw;
  logic [NUM_REQ*I2C_ADDR_W-1:0] req_addr;
  logic [NUM_REQ*I2C_DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [I2C_DATA_W-1:0]         rsp_rdata;
  logic [1:0]                    rsp_err;
  logic                          arb_busy;
  logic                          m_start;
  logic                          m_rw_bit;
  logic [I2C_ADDR_W-1:0]         m_slave_addr;
  logic [I2C_DATA_W-1:0]         m_tx_data;
  logic [I2C_DATA_W-1:0]         m_rx_data;
  logic                          m_busy;
  logic                          m_done;
  logic                          m_ack_error;

  modport master (
    input  req_valid, req_rw, req_addr, req_wdata, m_rx_data, m_busy, m_done, m_ack_error,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, arb_busy, m_start, m_rw_bit,
           m_slave_addr, m_tx_data
  );
  modport slave (
    output req_valid, req_rw, req_addr, req_wdata, m_rx_data, m_busy, m_done, m_ack_error,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, arb_busy, m_start, m_rw_bit,
           m_slave_addr, m_tx_data
  );
endinterface

// File: rtl/i2c_master_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester strictly after 'last', wrapping.
module rr_arbiter #(parameter int N = 3) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx
);
  import i2c_arb_pkg::*;
  localparam int IW = $clog2(N);

  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(last) + k) % N);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end
endmodule

// File: rtl/i2c_master_arbiter.sv
// Shares one i2c_master among NUM_REQ requesters: round-robin accept, start/wait,
// NACK retry with a gap, timeout abort, one-cycle response per transaction.
module i2c_master_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ       = 3,
  parameter int MAX_RETRY     = 2,
  parameter int RETRY_GAP_CYC = 1000,
  parameter int TIMEOUT_CYC   = 2_000_000
) (
  input logic                 clk,
  input logic                 rst,
  i2c_master_arbiter_if.master bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int RW = cnt_w(MAX_RETRY);
  localparam int GW = cnt_w(RETRY_GAP_CYC);
  localparam int TW = cnt_w(TIMEOUT_CYC);

  arb_state_t            state_q, state_d;
  logic [IW-1:0]         grant_q, grant_d, last_q, last_d;
  logic                  rw_q, rw_d;
  logic [I2C_ADDR_W-1:0] addr_q, addr_d;
  logic [I2C_DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0]            err_q, err_d;
  logic [RW-1:0]         retry_q, retry_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic [TW-1:0]         tmo_q, tmo_d;

  logic [NUM_REQ-1:0]                 arb_gnt;
  logic [IW-1:0]                      arb_idx;
  logic [NUM_REQ-1:0][I2C_ADDR_W-1:0] addr_arr;
  logic [NUM_REQ-1:0][I2C_DATA_W-1:0] wdata_arr;

  assign addr_arr  = bus.req_addr;
  assign wdata_arr = bus.req_wdata;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req  (bus.req_valid),
    .last (last_q),
    .gnt  (arb_gnt),
    .idx  (arb_idx)
  );

  assign bus.arb_busy     = (state_q != IDLE);
  assign bus.m_rw_bit     = rw_q;
  assign bus.m_slave_addr = addr_q;
  assign bus.m_tx_data    = wdata_q;
  assign bus.rsp_rdata    = rdata_q;
  assign bus.rsp_err      = err_q;

  always_comb begin
    state_d = state_q;  grant_d = grant_q;  last_d  = last_q;
    rw_d    = rw_q;     addr_d  = addr_q;   wdata_d = wdata_q;
    rdata_d = rdata_q;  err_d   = err_q;
    retry_d = retry_q;  gap_d   = gap_q;    tmo_d   = tmo_q;
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    bus.m_start   = 1'b0;
    unique case (state_q)
      IDLE: if (|bus.req_valid) begin
        bus.req_ready = arb_gnt;
        grant_d = arb_idx;
        rw_d    = bus.req_rw[arb_idx];
        addr_d  = addr_arr[arb_idx];
        wdata_d = wdata_arr[arb_idx];
        retry_d = '0;
        state_d = ISSUE;
      end
      // Also covers a master still busy with a transaction we timed out on.
      ISSUE: if (!bus.m_busy) begin
        bus.m_start = 1'b1;
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        tmo_d = tmo_q + 1'b1;
        if (bus.m_done) begin
          if (!bus.m_ack_error) begin
            rdata_d = rw_q ? bus.m_rx_data : '0;
            err_d   = ERR_OK;
            state_d = RESP;
          end else if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + 1'b1;
            gap_d   = '0;
            state_d = GAP;
          end else begin
            rdata_d = '0;
            err_d   = ERR_NACK;
            state_d = RESP;
          end
        end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
          rdata_d = '0;
          err_d   = ERR_TIMEOUT;
          state_d = RESP;
        end
      end
      GAP: begin
        if (gap_q == GW'(RETRY_GAP_CYC - 1)) state_d = ISSUE;
        else                                 gap_d   = gap_q + 1'b1;
      end
      RESP: begin
        bus.rsp_valid[grant_q] = 1'b1;
        last_d  = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(NUM_REQ - 1);
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= ERR_OK;
      retry_q <= '0;
      gap_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      retry_q <= retry_d;
      gap_q   <= gap_d;
      tmo_q   <= tmo_d;
    end
  end
endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed bench for i2c_master_arbiter with a behavioural i2c_master (programmable NACKs/latency).
module tb_i2c_master_arbiter;
  import i2c_arb_pkg::*;

  localparam int NR = 3, MR = 2, GAPC = 8, TMO = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i2c_master_arbiter_if #(.NUM_REQ(NR)) bus();

  i2c_master_arbiter #(
    .NUM_REQ(NR), .MAX_RETRY(MR), .RETRY_GAP_CYC(GAPC), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- behavioural i2c_master ----------------
  int         mdl_lat   = 2;
  int         mdl_nacks = 0;   // 255 = NACK forever
  int         mdl_base  = 0;
  logic       mdl_hang  = 1'b0;
  logic [7:0] mdl_rdata = 8'h00;
  int         n_done    = 0;
  int         lat_cnt   = 0;

  always @(posedge clk) begin
    bus.m_done <= 1'b0;
    if (rst) begin
      bus.m_busy      <= 1'b0;
      bus.m_ack_error <= 1'b0;
      bus.m_rx_data   <= 8'h00;
      lat_cnt         <= 0;
    end else if (!bus.m_busy) begin
      if (bus.m_start) begin
        bus.m_busy <= 1'b1;
        lat_cnt    <= mdl_lat;
      end
    end else if (!mdl_hang) begin
      if (lat_cnt == 0) begin
        bus.m_busy      <= 1'b0;
        bus.m_done      <= 1'b1;
        bus.m_ack_error <= (mdl_nacks == 255) || ((n_done - mdl_base) < mdl_nacks);
        bus.m_rx_data   <= mdl_rdata;
        n_done          <= n_done + 1;
      end else begin
        lat_cnt <= lat_cnt - 1;
      end
    end
  end

  // ---------------- monitor (samples on falling edge) ----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_start = 0, start_cyc = 0, done_cyc = 0, n_rsp = 0, rsp_cyc = 0;
  int         min_gap = 1_000_000, rsp_min_gap = 1_000_000;
  logic       done_since_rsp = 1'b0;
  logic [2:0] rsp_vec = '0;
  logic [1:0] rsp_e = '0;
  logic [7:0] rsp_d = '0;
  logic [6:0] st_addr = '0;
  logic       st_rw = 1'b0;
  logic [7:0] st_tx = '0;

  always @(negedge clk) begin
    if (rst) begin
      done_since_rsp = 1'b0;
      min_gap        = 1_000_000;
    end else begin
      if (bus.m_done === 1'b1) begin
        done_cyc       = cyc;
        done_since_rsp = 1'b1;
      end
      if (bus.m_start === 1'b1) begin
        if (done_since_rsp && (cyc - done_cyc) < min_gap) min_gap = cyc - done_cyc;
        n_start++;
        start_cyc = cyc;
        st_addr   = bus.m_slave_addr;
        st_rw     = bus.m_rw_bit;
        st_tx     = bus.m_tx_data;
      end
      if (bus.rsp_valid !== 3'b000) begin
        n_rsp++;
        rsp_cyc        = cyc;
        rsp_vec        = bus.rsp_valid;
        rsp_e          = bus.rsp_err;
        rsp_d          = bus.rsp_rdata;
        rsp_min_gap    = min_gap;
        min_gap        = 1_000_000;
        done_since_rsp = 1'b0;
      end
    end
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  logic [2:0][6:0] addr_v  = '0;
  logic [2:0][7:0] wdata_v = '0;
  logic [2:0]      rw_v    = '0;

  task automatic drive_cmd(input logic [1:0] r, input logic rw, input logic [6:0] a,
                           input logic [7:0] d);
    rw_v[r] = rw;  addr_v[r] = a;  wdata_v[r] = d;
    bus.req_rw    = rw_v;
    bus.req_addr  = addr_v;
    bus.req_wdata = wdata_v;
  endtask

  task automatic wait_rsp(input int r0, input int budget, output bit got);
    got = 1'b0;
    for (int k = 0; k < budget && !got; k++) begin
      @(negedge clk); #2;
      got = (n_rsp != r0);
    end
  endtask

  typedef struct {
    logic [1:0] r;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    int         nacks;
    int         lat;
    logic [7:0] rdata;
    logic [1:0] eerr;
    logic [7:0] erdata;
    int         estarts;
  } vec_t;

  task automatic run_txn(input vec_t v);
    int s0, r0;
    bit got;
    mdl_base = n_done;  mdl_nacks = v.nacks;  mdl_lat = v.lat;  mdl_rdata = v.rdata;
    s0 = n_start;  r0 = n_rsp;
    @(negedge clk); #2;
    drive_cmd(v.r, v.rw, v.addr, v.wdata);
    bus.req_valid = 3'b001 << v.r;
    #1;
    chk("txn_ready", 32'(bus.req_ready), 32'(3'b001 << v.r));
    @(negedge clk); #2;
    bus.req_valid = '0;
    wait_rsp(r0, 2000, got);
    chk("txn_rsp_seen", 32'(got), 32'd1);
    chk("txn_rsp_valid", 32'(rsp_vec), 32'(3'b001 << v.r));
    chk("txn_rsp_err", 32'(rsp_e), 32'(v.eerr));
    chk("txn_rsp_rdata", 32'(rsp_d), 32'(v.erdata));
    chk("txn_starts", 32'(n_start - s0), 32'(v.estarts));
    chk("txn_m_addr", 32'(st_addr), 32'(v.addr));
    chk("txn_m_rw", 32'(st_rw), 32'(v.rw));
    chk("txn_m_tx", 32'(st_tx), 32'(v.wdata));
    // Response follows m_done by one cycle; a timeout is declared on the
    // TMO-th cycle after the start pulse and answered one cycle later.
    if (v.eerr == ERR_TIMEOUT) chk("txn_tmo_lat", 32'(rsp_cyc - start_cyc), 32'(TMO + 1));
    else                       chk("txn_done_lat", 32'(rsp_cyc - done_cyc), 32'd1);
    if (v.estarts > 1)         chk("txn_retry_gap_ge", 32'(rsp_min_gap >= GAPC + 1), 32'd1);
    @(negedge clk); #2;
    chk("txn_rsp_one_cycle", 32'(bus.rsp_valid), 32'd0);
  endtask

  // Serve all currently valid requesters; grants must come in the given order.
  task automatic drain(input logic [1:0] o0, input logic [1:0] o1, input logic [1:0] o2,
                       input int r0);
    logic [1:0] ord [3];
    logic [2:0] rdy;
    bit got;
    ord[0] = o0;  ord[1] = o1;  ord[2] = o2;
    for (int i = 0; i < 3; i++) begin
      got = 1'b0;
      rdy = '0;
      for (int k = 0; k < 3000 && !got; k++) begin
        rdy = bus.req_ready;
        got = (rdy != 3'b000);
        if (!got) begin @(negedge clk); #3; end
      end
      chk("order_wait", 32'(got), 32'd1);
      chk("order_onehot", 32'($countones(rdy)), 32'd1);
      chk("order_grant", 32'(rdy), 32'(3'b001 << ord[i]));
      @(negedge clk); #2;
      bus.req_valid = bus.req_valid & ~rdy;
      #1;
    end
    for (int k = 0; k < 3000 && n_rsp != r0 + 3; k++) begin @(negedge clk); #2; end
    chk("order_rsp_count", 32'(n_rsp - r0), 32'd3);
  endtask

  vec_t tbl [9];

  initial begin
    int s0, r0;
    bit got;

    tbl[0] = '{2'd0, 1'b0, 7'h55, 8'hFF, 0,   3,  8'h00, ERR_OK,      8'h00, 1};
    tbl[1] = '{2'd1, 1'b0, 7'h20, 8'h3C, 0,   1,  8'hEE, ERR_OK,      8'h00, 1};
    tbl[2] = '{2'd2, 1'b1, 7'h57, 8'h00, 0,   4,  8'hA5, ERR_OK,      8'hA5, 1};
    tbl[3] = '{2'd0, 1'b0, 7'h10, 8'h11, 255, 2,  8'h00, ERR_NACK,    8'h00, 3};
    tbl[4] = '{2'd1, 1'b1, 7'h22, 8'h00, 1,   2,  8'h3E, ERR_OK,      8'h3E, 2};
    tbl[5] = '{2'd2, 1'b1, 7'h33, 8'h00, 255, 0,  8'h77, ERR_NACK,    8'h00, 3};
    tbl[6] = '{2'd0, 1'b1, 7'h44, 8'h00, 2,   5,  8'h81, ERR_OK,      8'h81, 3};
    tbl[7] = '{2'd2, 1'b0, 7'h66, 8'h5A, 0,   98, 8'h00, ERR_OK,      8'h00, 1};
    tbl[8] = '{2'd1, 1'b0, 7'h12, 8'h34, 0,   99, 8'h00, ERR_TIMEOUT, 8'h00, 1};

    bus.req_valid = '0;
    bus.req_rw    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    chk("rst_arb_busy", 32'(bus.arb_busy), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_m_start", 32'(bus.m_start), 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    chk("rst_m_addr", 32'(bus.m_slave_addr), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);

    for (int i = 0; i < 9; i++) run_txn(tbl[i]);

    // All three request at once after requester 1 was served last.
    mdl_base = n_done;  mdl_nacks = 0;  mdl_lat = 2;
    r0 = n_rsp;
    @(negedge clk); #2;
    drive_cmd(2'd0, 1'b0, 7'h01, 8'h10);
    drive_cmd(2'd1, 1'b0, 7'h02, 8'h20);
    drive_cmd(2'd2, 1'b0, 7'h03, 8'h30);
    bus.req_valid = 3'b111;
    #1;
    drain(2'd2, 2'd0, 2'd1, r0);

    // Master never completes: timeout, then the next issue waits for m_busy=0.
    mdl_base = n_done;  mdl_nacks = 0;  mdl_lat = 5;  mdl_hang = 1'b1;
    s0 = n_start;  r0 = n_rsp;
    @(negedge clk); #2;
    drive_cmd(2'd1, 1'b1, 7'h4A, 8'h00);
    bus.req_valid = 3'b010;
    @(negedge clk); #2;
    bus.req_valid = '0;
    wait_rsp(r0, 500, got);
    chk("tmo_rsp_seen", 32'(got), 32'd1);
    chk("tmo_rsp_err", 32'(rsp_e), 32'(ERR_TIMEOUT));
    chk("tmo_rsp_rdata", 32'(rsp_d), 32'd0);
    chk("tmo_latency", 32'(rsp_cyc - start_cyc), 32'(TMO + 1));
    @(negedge clk); #2;
    drive_cmd(2'd2, 1'b0, 7'h5B, 8'hC3);
    bus.req_valid = 3'b100;
    #1;
    chk("tmo_next_ready", 32'(bus.req_ready), 32'b100);
    @(negedge clk); #2;
    bus.req_valid = '0;
    repeat (20) @(negedge clk);
    #2;
    chk("tmo_stall_no_start", 32'(n_start - s0), 32'd1);
    chk("tmo_stall_busy", 32'(bus.arb_busy), 32'd1);
    mdl_hang = 1'b0;
    wait_rsp(r0 + 1, 500, got);
    chk("tmo_next_rsp_seen", 32'(got), 32'd1);
    chk("tmo_next_rsp_valid", 32'(rsp_vec), 32'b100);
    chk("tmo_next_rsp_err", 32'(rsp_e), 32'(ERR_OK));
    chk("tmo_next_starts", 32'(n_start - s0), 32'd2);
    chk("tmo_next_m_addr", 32'(st_addr), 32'h5B);
    repeat (5) @(negedge clk);
    #2;
    chk("tmo_late_done_ignored", 32'(n_rsp - r0), 32'd2);

    // Reset while waiting on the master; nothing answers the abandoned command.
    mdl_base = n_done;  mdl_nacks = 0;  mdl_lat = 2;  mdl_hang = 1'b1;
    s0 = n_start;  r0 = n_rsp;
    @(negedge clk); #2;
    drive_cmd(2'd1, 1'b0, 7'h6C, 8'h99);
    bus.req_valid = 3'b010;
    @(negedge clk); #2;
    bus.req_valid = '0;
    for (int k = 0; k < 50 && n_start == s0; k++) begin @(negedge clk); #2; end
    repeat (3) @(negedge clk);
    #2;
    chk("rstw_in_wait", 32'(bus.arb_busy), 32'd1);
    drive_cmd(2'd0, 1'b0, 7'h0A, 8'hA0);
    drive_cmd(2'd1, 1'b0, 7'h0B, 8'hB0);
    drive_cmd(2'd2, 1'b0, 7'h0C, 8'hC0);
    bus.req_valid = 3'b111;
    rst = 1'b1;
    @(negedge clk); #2;
    rst = 1'b0;
    mdl_hang = 1'b0;
    mdl_base = n_done;
    #1;
    chk("rstw_arb_busy", 32'(bus.arb_busy), 32'd0);
    chk("rstw_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rstw_m_start", 32'(bus.m_start), 32'd0);
    chk("rstw_m_addr", 32'(bus.m_slave_addr), 32'd0);
    chk("rstw_m_tx", 32'(bus.m_tx_data), 32'd0);
    chk("rstw_no_rsp", 32'(n_rsp - r0), 32'd0);
    drain(2'd0, 2'd1, 2'd2, r0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit actual=expired required=finish");
    $fatal(1);
  end
endmodule
